// File: rtl/sevenseg_pkg.sv
// Seven-segment glyph definitions shared by the display controller and its decoder.
// Segment vectors are active-high and ordered {CA,CB,CC,CD,CE,CF,CG}.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,  // 0 1 2 3
    7'h33, 7'h5B, 7'h5F, 7'h70,  // 4 5 6 7
    7'h7F, 7'h7B, 7'h77, 7'h1F,  // 8 9 A b
    7'h4E, 7'h3D, 7'h4F, 7'h47   // C d E F
  };

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-high segment pattern; output polarity is
// applied by the instantiating controller.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/sevenseg_mux_ctrl.sv
// Tear-free multiplexed seven-segment controller with double-buffered frame data.
// Define SEVENSEG_DIMMING_EN to build the PWM brightness gate; otherwise i_brightness is ignored.
module sevenseg_mux_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int REFRESH_DIV      = 12500,
  parameter int GUARD            = 4,
  parameter int BRIGHT_W         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]     GUARD_V   = SLOT_W'(GUARD);
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam seg_t                  SEG_OFF   = {7{SEG_ACTIVE_LOW}};

  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
  logic                  pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;

  logic                  boundary;
  logic                  gate_open;
  logic                  lit;
  logic [3:0]            act_nib [NUM_DIGITS];
  logic [3:0]            cur_nib;
  seg_t                  cur_seg;

`ifdef SEVENSEG_DIMMING_EN
  logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + BRIGHT_W'(1);
  assign gate_open = (pwm_cnt_q <= i_brightness);

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^i_brightness;
  assign gate_open         = 1'b1;
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign act_nib[gi] = act_digits_q[4*gi +: 4];
    end
  endgenerate

  assign cur_nib = act_nib[dig_idx_q];

  sevenseg_decode u_decode (
    .i_nibble (cur_nib),
    .o_seg    (cur_seg)
  );

  always_comb begin
    boundary     = (slot_cnt_q == '0) && (dig_idx_q == '0);
    slot_cnt_d   = slot_cnt_q + SLOT_W'(1);
    dig_idx_d    = dig_idx_q;
    pending_d    = pending_q;
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_blank_d  = stg_blank_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + DIG_W'(1);
    end

    // While pending, o_ready is low, so a capture can never collide with the copy.
    if (boundary && pending_q) begin
      act_digits_d = stg_digits_q;
      act_dp_d     = stg_dp_q;
      act_blank_d  = stg_blank_q;
      pending_d    = 1'b0;
    end else if (i_valid && !pending_q) begin
      stg_digits_d = i_digits;
      stg_dp_d     = i_dp;
      stg_blank_d  = i_blank;
      pending_d    = 1'b1;
    end

    lit           = (slot_cnt_q >= GUARD_V) && !act_blank_q[dig_idx_q] && gate_open;
    an_d          = (lit ? (NUM_DIGITS'(1) << dig_idx_q) : '0) ^ AN_OFF;
    seg_d         = (lit ? cur_seg : '0) ^ SEG_OFF;
    dp_d          = (lit & act_dp_q[dig_idx_q]) ^ SEG_ACTIVE_LOW;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= '0;
      pending_q     <= 1'b0;
      stg_digits_q  <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= SEG_ACTIVE_LOW;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      pending_q     <= pending_d;
      stg_digits_q  <= stg_digits_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_ready       = !pending_q;
  assign o_an          = an_q;
  assign o_seg         = seg_q;
  assign o_dp          = dp_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Self-checking bench for sevenseg_mux_ctrl: a time-indexed reference model checks every
// cycle, while directed sequences and a decode table cover the frame-level corner cases.
module tb_sevenseg_mux_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 16;
  localparam int GD    = 2;
  localparam int BW    = 2;
  localparam int FRAME = ND * RD;

`ifdef SEVENSEG_DIMMING_EN
  localparam int ON_B1 = 6;   // visible slot cycles with pwm <= 1
  localparam int ON_B0 = 3;   // visible slot cycles with pwm == 0
`else
  localparam int ON_B1 = 14;
  localparam int ON_B0 = 14;
`endif

  // Active-low glyphs {CA..CG} for 0..F.
  localparam logic [6:0] HEX_LO [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct {
    logic [3:0] nib;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
  } vec_t;

  logic            clk_core = 1'b0;
  logic            rst_core = 1'b1;
  logic [4*ND-1:0] i_digits = '0;
  logic [ND-1:0]   i_dp = '0;
  logic [ND-1:0]   i_blank = '0;
  logic            i_valid = 1'b0;
  logic [BW-1:0]   i_brightness = '0;
  logic            o_ready;
  logic [ND-1:0]   o_an;
  logic [6:0]      o_seg;
  logic            o_dp;
  logic            o_frame_start;

  int n_total = 0;
  int n_bad   = 0;

  sevenseg_mux_ctrl #(
    .NUM_DIGITS       (ND),
    .REFRESH_DIV      (RD),
    .GUARD            (GD),
    .BRIGHT_W         (BW),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_core      (clk_core),
    .rst_core      (rst_core),
    .i_digits      (i_digits),
    .i_dp          (i_dp),
    .i_blank       (i_blank),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_brightness  (i_brightness),
    .o_an          (o_an),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame_start (o_frame_start)
  );

  always #5 clk_core = ~clk_core;

  // Reference model: position in the frame is just cycles since reset modulo the frame.
  int         m_t = 0;
  bit         m_ok = 1'b0;
  bit         m_pend = 1'b0;
  logic [15:0] m_sd = '0, m_ad = '0;
  logic [3:0] m_sdp = '0, m_adp = '0, m_sb = '0, m_ab = '1;

  always @(posedge clk_core) begin
    int slot, dig, pwm;
    bit lit, gate;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs, e_rdy;
    if (rst_core) begin
      m_t = 0; m_pend = 0; m_ab = 4'hF; m_ad = '0; m_adp = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_rdy = 1'b1;
      m_ok = 1'b1;
    end else begin
      slot = m_t % RD;
      dig  = (m_t / RD) % ND;
      pwm  = m_t % (1 << BW);
`ifdef SEVENSEG_DIMMING_EN
      gate = (pwm <= int'(i_brightness));
`else
      gate = 1'b1;
`endif
      lit   = (slot >= GD) && !m_ab[dig] && gate;
      e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
      e_seg = lit ? HEX_LO[m_ad[4*dig +: 4]] : 7'h7F;
      e_dp  = lit ? ~m_adp[dig] : 1'b1;
      e_fs  = (m_t == 0);
      if (m_t == 0 && m_pend) begin
        m_ad = m_sd; m_adp = m_sdp; m_ab = m_sb; m_pend = 0;
      end else if (i_valid && !m_pend) begin
        m_sd = i_digits; m_sdp = i_dp; m_sb = i_blank; m_pend = 1;
      end
      e_rdy = !m_pend;
      m_t = (m_t + 1) % FRAME;
    end
    #1;
    if (m_ok) begin
      n_total++;
      if (o_an !== e_an || o_seg !== e_seg || o_dp !== e_dp ||
          o_frame_start !== e_fs || o_ready !== e_rdy) begin
        n_bad++;
        $display("FAIL cycle t=%0t an=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b rdy=%b/%b (actual/required)",
                 $time, o_an, e_an, o_seg, e_seg, o_dp, e_dp, o_frame_start, e_fs, o_ready, e_rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 3 * FRAME) begin tick(); n++; end
    check(name, int'(o_ready), 1);
  endtask

  // Hand over a frame and return on the first sample of the frame that shows it.
  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    wait_ready("load_ready_in");
    i_digits = d; i_dp = dp; i_blank = bl; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    $display("load digits=%h dp=%b blank=%b bright=%0d", d, dp, bl, i_brightness);
    wait_ready("load_copied");
  endtask

  vec_t vecs [16];

  initial begin
    int n, d0, dpd2, dpo, an_err, seg52, seg4, any_lit;
    int cnt [ND];

    vecs[0]  = '{4'h0, 7'h01, 4'b1110}; vecs[1]  = '{4'h1, 7'h4F, 4'b1110};
    vecs[2]  = '{4'h2, 7'h12, 4'b1110}; vecs[3]  = '{4'h3, 7'h06, 4'b1110};
    vecs[4]  = '{4'h4, 7'h4C, 4'b1110}; vecs[5]  = '{4'h5, 7'h24, 4'b1110};
    vecs[6]  = '{4'h6, 7'h20, 4'b1110}; vecs[7]  = '{4'h7, 7'h0F, 4'b1110};
    vecs[8]  = '{4'h8, 7'h00, 4'b1110}; vecs[9]  = '{4'h9, 7'h04, 4'b1110};
    vecs[10] = '{4'hA, 7'h08, 4'b1110}; vecs[11] = '{4'hB, 7'h60, 4'b1110};
    vecs[12] = '{4'hC, 7'h31, 4'b1110}; vecs[13] = '{4'hD, 7'h42, 4'b1110};
    vecs[14] = '{4'hE, 7'h30, 4'b1110}; vecs[15] = '{4'hF, 7'h38, 4'b1110};

    // Reset release
    rst_core = 1'b1;
    tick(); tick(); tick();
    check("rst_an", int'(o_an), 'hF);
    check("rst_seg", int'(o_seg), 'h7F);
    check("rst_dp", int'(o_dp), 1);
    check("rst_ready", int'(o_ready), 1);
    check("rst_fs", int'(o_frame_start), 0);
    rst_core = 1'b0;
    tick();
    check("first_fs", int'(o_frame_start), 1);
    n = 0;
    do begin tick(); n++; end while (!o_frame_start && n < 200);
    check("fs_period", n, FRAME);

    // Decode table, one frame per glyph
    i_brightness = 2'd3;
    for (int i = 0; i < 16; i++) begin
      load({4{vecs[i].nib}}, 4'b0000, 4'b0000);
      repeat (4) tick();
      check($sformatf("dec_seg_%h", vecs[i].nib), int'(o_seg), int'(vecs[i].exp_seg));
      check($sformatf("dec_an_%h", vecs[i].nib), int'(o_an), int'(vecs[i].exp_an));
    end

    // Load and display
    load(16'h3210, 4'b0100, 4'b0000);
    d0 = 0; dpd2 = 0; dpo = 0; an_err = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (o_an == 4'b1110 && o_seg == 7'h01) d0++;
      if (!o_dp && o_an == 4'b1011) dpd2++;
      if (!o_dp && o_an != 4'b1011) dpo++;
      if (k % RD == 8 && o_an != ~(4'b0001 << (k / RD))) an_err++;
      tick();
    end
    check("disp_d0_cycles", d0, RD - GD);
    check("disp_dp_d2", dpd2, RD - GD);
    check("disp_dp_other", dpo, 0);
    check("disp_an_seq_err", an_err, 0);

    // Tear-free update: handshake in cycle 20 of the frame
    repeat (19) tick();
    i_digits = 16'hABCD; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    $display("load digits=abcd at frame cycle 20");
    check("tear_ready_drop", int'(o_ready), 0);
    n = 0; seg52 = -1;
    while (!o_ready && n < 200) begin
      tick(); n++;
      if (n == 32) seg52 = int'(o_seg);
    end
    check("tear_ready_low", n, FRAME - 20);
    check("tear_old_d3", seg52, 'h06);
    repeat (4) tick();
    check("tear_new_d0", int'(o_seg), 'h42);

    // Handshake in the boundary cycle itself
    repeat (59) tick();
    i_digits = 16'h7777; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    $display("load digits=7777 in boundary cycle");
    check("sim_ready_drop", int'(o_ready), 0);
    n = 0; seg4 = -1;
    while (!o_ready && n < 200) begin
      tick(); n++;
      if (n == 4) seg4 = int'(o_seg);
    end
    check("sim_wait", n, FRAME);
    check("sim_old_d0", seg4, 'h42);
    repeat (4) tick();
    check("sim_new_d0", int'(o_seg), 'h0F);

    // Blank and dimming
    i_brightness = 2'd1;
    load(16'h9876, 4'b0000, 4'b0010);
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    for (int k = 0; k < FRAME; k++) begin
      for (int d = 0; d < ND; d++) if (o_an == ~(4'b0001 << d)) cnt[d]++;
      tick();
    end
    check("blank_d1", cnt[1], 0);
    check("dim_d0", cnt[0], ON_B1);
    check("dim_d2", cnt[2], ON_B1);
    check("dim_d3", cnt[3], ON_B1);

    // Reset mid-frame with data pending
    i_brightness = 2'd3;
    i_digits = 16'h8888; i_blank = 4'b0000; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    $display("load digits=8888 then reset");
    check("midrst_pending", int'(o_ready), 0);
    repeat (3) tick();
    rst_core = 1'b1;
    tick();
    check("midrst_an", int'(o_an), 'hF);
    check("midrst_seg", int'(o_seg), 'h7F);
    check("midrst_dp", int'(o_dp), 1);
    check("midrst_ready", int'(o_ready), 1);
    rst_core = 1'b0;
    any_lit = 0;
    repeat (2 * FRAME) begin
      tick();
      if (o_an != 4'hF) any_lit++;
    end
    check("midrst_never_lit", any_lit, 0);

    // Lowest brightness after the reset
    i_brightness = 2'd0;
    load(16'h1111, 4'b0000, 4'b0000);
    n = 0;
    for (int k = 0; k < RD; k++) begin
      if (o_an == 4'b1110) n++;
      tick();
    end
    check("bright0_d0", n, ON_B0);

    // Randomised traffic, checked cycle by cycle by the model
    for (int c = 0; c < 2000; c++) begin
      i_digits     = 16'($urandom);
      i_dp         = 4'($urandom);
      i_blank      = 4'($urandom);
      i_brightness = 2'($urandom);
      i_valid      = ($urandom_range(0, 15) == 0);
      rst_core     = ($urandom_range(0, 499) == 0);
      if (i_valid && o_ready && !rst_core)
        $display("rand load digits=%h dp=%b blank=%b", i_digits, i_dp, i_blank);
      tick();
    end
    i_valid = 1'b0;
    rst_core = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_mux_ctrl.md
# sevenseg_mux_ctrl

Parametrised, tear-free multiplexed seven-segment display controller for the SweRVolf Nexys A7 SoC. It replaces the fixed 8-digit AN/CA..CG driver behind the board's display pins and adds four things the old driver lacks: configurable digit count, per-digit blanking and decimal point, double-buffered frame-synchronous updates, and PWM brightness control. It sits in the `clk_core` domain between the bus-side register block and the top-level pad outputs.

## Interface
- `NUM_DIGITS`, 8: number of multiplexed digits, 1–16.
- `REFRESH_DIV`, 12500: `clk_core` cycles per digit slot; must be greater than `GUARD`.
- `GUARD`, 4: anode-off cycles at the start of each slot (anti-ghosting).
- `BRIGHT_W`, 4: brightness width.
- `ANODE_ACTIVE_LOW`, 1: anode polarity.
- `SEG_ACTIVE_LOW`, 1: segment and dp polarity.

Ports, clock and reset first:
- `clk_core` in 1: the single clock.
- `rst_core` in 1: reset, synchronous, active-high.
- `i_digits` in 4*NUM_DIGITS: hex nibbles; digit k is `[4k+3:4k]`.
- `i_dp` in NUM_DIGITS: decimal-point enables.
- `i_blank` in NUM_DIGITS: 1 = digit dark.
- `i_valid` in 1: new frame data offered.
- `o_ready` out 1: staging buffer free.
- `i_brightness` in BRIGHT_W: duty level.
- `o_an` out NUM_DIGITS: anodes.
- `o_seg` out 7: segments, ordered {CA,CB,CC,CD,CE,CF,CG}.
- `o_dp` out 1: decimal point.
- `o_frame_start` out 1: one-cycle pulse at the start of each frame.

## Operation
- Counters:
  - `slot_cnt` counts 0..REFRESH_DIV-1.
  - `dig_idx` counts 0..NUM_DIGITS-1; it advances when `slot_cnt` wraps, and wraps itself from NUM_DIGITS-1 to 0.
  - `pwm_cnt` is a free-running BRIGHT_W-bit counter that wraps naturally.
- Frame boundary: the cycle in which `slot_cnt`==0 and `dig_idx`==0.
- Buffering. There are two register sets: staging and active. Each holds digits, dp and blank.
  - `i_valid && o_ready` captures the inputs into staging, sets `pending`, and drops `o_ready` the next cycle.
  - At a frame boundary with `pending`=1, staging is copied to active and `pending` clears. `o_ready` rises the following cycle.
  - The active set never changes mid-frame.
- Simultaneous handshake and frame boundary: the capture goes to staging only. It reaches active at the next frame boundary; there is no bypass.
- Digit lit condition (all must hold): `slot_cnt` >= GUARD, `active_blank[dig_idx]`==0, and the brightness gate is open.
- Brightness gate: `pwm_cnt` <= `i_brightness`, so the duty cycle is (brightness+1)/2^BRIGHT_W; all-ones means always on.
- When lit: the anode for `dig_idx` is asserted, `o_seg` = hex decode of the active nibble, and `o_dp` = `active_dp[dig_idx]`.
- Otherwise: all anodes, segments and dp are inactive.
- Hex decode uses the standard patterns 0–9 and A, b, C, d, E, F. Example: 0 → CA..CF on, CG off.
- Polarity: output levels are inverted per `ANODE_ACTIVE_LOW` and `SEG_ACTIVE_LOW`. "Inactive" always means the deasserted electrical level.
- Reset:
  - `slot_cnt`, `dig_idx`, `pwm_cnt` and `pending` are cleared to 0.
  - Active blank is all ones; digits and dp are 0.
  - `o_ready` = 1, `o_frame_start` = 0, and all display outputs are inactive.
  - A reset in mid-frame discards any pending staging data.

## Timing
- All outputs are registered: display outputs reflect the counter and active state of the previous cycle, i.e. one-cycle latency.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles. Each digit is visible for at most REFRESH_DIV-GUARD cycles per frame.
- `o_frame_start` is high for the one cycle after each frame-boundary cycle.
- Handshake-to-display latency: from 1 up to NUM_DIGITS*REFRESH_DIV cycles until the next boundary, plus 1 for the output register.
- `i_brightness` is sampled every cycle with no synchronisation. It is a `clk_core`-domain signal.

## Configuration
- `SEVENSEG_DIMMING_EN` defined: the `pwm_cnt` and brightness gate are built as described above.
- `SEVENSEG_DIMMING_EN` undefined:
  - The gate is constantly open and `pwm_cnt` is removed.
  - The `i_brightness` port remains but is ignored.
  - All other behaviour, including GUARD, is unchanged.

## Structure
- `sevenseg_pkg` holds:
  - `seg_t`, a 7-bit typedef;
  - the 16-entry hex-to-segment constant table, active-high, {CA..CG};
  - the function `hex2seg`.
- One sub-module, `sevenseg_decode`: combinational nibble to `seg_t`, using `hex2seg`. Polarity inversion stays in the parent.

## Test plan
Unless a line states otherwise, all scenarios use NUM_DIGITS=4, REFRESH_DIV=16, GUARD=2, BRIGHT_W=2, both polarities active-low, and `SEVENSEG_DIMMING_EN` defined.
- Reset release:
  - Stimulus: hold `rst_core` for 3 cycles.
  - Response: `o_an`=4'b1111, `o_seg`=7'h7F, `o_dp`=1, `o_ready`=1.
  - The first `o_frame_start` pulse comes 1 cycle after release; the next one 64 cycles later.
- Load and display:
  - Stimulus: `i_digits`=16'h3210, `i_blank`=0, `i_dp`=4'b0100, `i_brightness`=3.
  - Response: after the next boundary, digit 0 shows `o_seg`=7'b0000001 for 14 of 16 slot cycles. `o_an` cycles 1110, 1101, 1011, 0111. `o_dp`=0 only in the digit-2 slot.
- Tear-free update:
  - Stimulus: handshake new data at cycle 20 of a frame.
  - Response: `o_ready`=0 until 1 cycle after the boundary; the old pattern persists for the rest of the frame.
- Simultaneous event:
  - Stimulus: `i_valid` in the boundary cycle.
  - Response: the data displays only from the following frame.
- Blank and dimming:
  - Stimulus: `i_blank`=4'b0010, `i_brightness`=1.
  - Response: digit 1 is never lit. Other digits are lit on exactly 2 of every 4 visible cycles.
- Reset mid-frame:
  - Stimulus: reset with `pending`=1.
  - Response: outputs go inactive the next cycle and the staged data is never displayed.
  - Repeat this scenario with `SEVENSEG_DIMMING_EN` undefined and `i_brightness`=0. Lit digits must be on for all visible cycles.
